cpu_bus_seq: RTL and testbench

- Parametrised bus sequencer between the 65c816 core control logic and memory.
- Turns one multi-byte access request (operand, pointer or long address; 1..MAX_BYTES bytes, little-endian) into a series of single-byte read or write cycles on the existing req_rdwr/which_rdwr/addr/data_out/data_in bus.
- Adds a memory-ready handshake and three address wrap modes (linear, bank, page).
- Successor to the single-byte request interface of the current core. Instantiated inside the core, between the state machine and the external bus.

---
 rtl/cpu_bus_seq.sv | 146 ++++++++++++++
 tb/tb_cpu_bus_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_seq.sv
// rtl/cpu_bus_seq.sv - multi-byte bus sequencer between the 65c816 core control logic and memory
// Splits one request into single-byte bus cycles with ack handshake and wrap modes.
module cpu_bus_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 24,
  parameter int MAX_BYTES  = 3,
  parameter int LEN_W      = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            start,
  input  logic                            start_write,
  input  logic [LEN_W-1:0]                start_len,
  input  logic [ADDR_WIDTH-1:0]           start_addr,
  input  logic [1:0]                      start_wrap,
  input  logic [MAX_BYTES*DATA_WIDTH-1:0] start_wdata,
  output logic                            busy,
  output logic                            done,
  output logic [MAX_BYTES*DATA_WIDTH-1:0] rdata,
  output logic                            req_rdwr,
  output logic                            which_rdwr,
  output logic [ADDR_WIDTH-1:0]           addr,
  output logic [DATA_WIDTH-1:0]           data_out,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            mem_ack
);

  localparam int WD_W = MAX_BYTES * DATA_WIDTH;
  localparam logic [LEN_W-1:0] LAST_MAX = LEN_W'(MAX_BYTES - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        k_q, k_d;
  logic [LEN_W-1:0]        last_q, last_d;
  logic [1:0]              wrap_q, wrap_d;
  logic [WD_W-1:0]         wdata_q, wdata_d;
  logic [WD_W-1:0]         wdata_shift;
  logic                    busy_d, done_d, req_d, which_d;
  logic [WD_W-1:0]         rdata_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   data_out_d;

  // Only the bits inside the wrap window increment; the bits above are kept.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] w);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] m;
    inc = a + ADDR_WIDTH'(1);
    case (w)
      2'd1:    m = ADDR_WIDTH'(17'h0FFFF);
      2'd2:    m = ADDR_WIDTH'(9'h0FF);
      default: m = '1;
    endcase
    return (a & ~m) | (inc & m);
  endfunction

  assign wdata_shift = wdata_q >> DATA_WIDTH;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    last_d     = last_q;
    wrap_d     = wrap_q;
    wdata_d    = wdata_q;
    busy_d     = busy;
    done_d     = done;
    req_d      = req_rdwr;
    which_d    = which_rdwr;
    rdata_d    = rdata;
    addr_d     = addr;
    data_out_d = data_out;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start) begin
          state_d    = XFER;
          k_d        = '0;
          last_d     = (start_len > LAST_MAX) ? LAST_MAX : start_len;
          wrap_d     = start_wrap;
          wdata_d    = start_wdata;
          rdata_d    = '0;
          busy_d     = 1'b1;
          req_d      = 1'b1;
          which_d    = start_write;
          addr_d     = start_addr;
          data_out_d = start_wdata[DATA_WIDTH-1:0];
        end
      end
      XFER: begin
        if (mem_ack) begin
          if (!which_rdwr) rdata_d[k_q*DATA_WIDTH +: DATA_WIDTH] = data_in;
          if (k_q == last_q) begin
            state_d = DONE;
            req_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            k_d        = k_q + LEN_W'(1);
            addr_d     = next_addr(addr, wrap_q);
            wdata_d    = wdata_shift;
            data_out_d = wdata_shift[DATA_WIDTH-1:0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      last_q     <= '0;
      wrap_q     <= '0;
      wdata_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      req_rdwr   <= 1'b0;
      which_rdwr <= 1'b0;
      rdata      <= '0;
      addr       <= '0;
      data_out   <= '0;
    end else if (enable) begin
      state_q    <= state_d;
      k_q        <= k_d;
      last_q     <= last_d;
      wrap_q     <= wrap_d;
      wdata_q    <= wdata_d;
      busy       <= busy_d;
      done       <= done_d;
      req_rdwr   <= req_d;
      which_rdwr <= which_d;
      rdata      <= rdata_d;
      addr       <= addr_d;
      data_out   <= data_out_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_seq.sv
// tb/tb_cpu_bus_seq.sv - directed self-checking bench for cpu_bus_seq
module tb_cpu_bus_seq;

  logic        clk = 1'b0;
  logic        rst, enable, start, start_write;
  logic [1:0]  start_len, start_wrap;
  logic [23:0] start_addr, start_wdata, rdata, addr;
  logic        busy, done, req_rdwr, which_rdwr, mem_ack;
  logic [7:0]  data_out, data_in;

  int checks = 0;
  int failures = 0;

  cpu_bus_seq dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .start_write(start_write),
    .start_len(start_len), .start_addr(start_addr), .start_wrap(start_wrap),
    .start_wdata(start_wdata), .busy(busy), .done(done), .rdata(rdata),
    .req_rdwr(req_rdwr), .which_rdwr(which_rdwr), .addr(addr), .data_out(data_out),
    .data_in(data_in), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // 2-byte read of 0x34,0x12 with ack held; second address is given by the caller.
  task automatic read2(input string tag, input logic [23:0] a0, input logic [1:0] w,
                       input logic [23:0] a1);
    start = 1'b1; start_write = 1'b0; start_len = 2'd1; start_addr = a0; start_wrap = w;
    mem_ack = 1'b1; data_in = 8'h34;
    tick();
    start = 1'b0;
    chk({tag, "_addr0"}, addr, a0);
    chk({tag, "_req0"}, req_rdwr, 1);
    chk({tag, "_busy0"}, busy, 1);
    chk({tag, "_which0"}, which_rdwr, 0);
    tick();
    data_in = 8'h12;
    chk({tag, "_addr1"}, addr, a1);
    chk({tag, "_req1"}, req_rdwr, 1);
    chk({tag, "_done_early"}, done, 0);
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_req_off"}, req_rdwr, 0);
    chk({tag, "_addr_hold"}, addr, a1);
    chk({tag, "_rdata"}, rdata, 24'h001234);
    tick();
    chk({tag, "_done_off"}, done, 0);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_rdata_hold"}, rdata, 24'h001234);
  endtask

  initial begin
    logic [7:0] wbytes [3];
    logic [7:0] rbytes [3];
    wbytes[0] = 8'hEF; wbytes[1] = 8'hCD; wbytes[2] = 8'hAB;
    rbytes[0] = 8'h11; rbytes[1] = 8'h22; rbytes[2] = 8'h33;

    rst = 1'b1; enable = 1'b1; start = 1'b0; start_write = 1'b0; start_len = 2'd0;
    start_addr = 24'h0; start_wrap = 2'd0; start_wdata = 24'h0; mem_ack = 1'b0; data_in = 8'h0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", req_rdwr, 0);
    chk("rst_which", which_rdwr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_rdata", rdata, 0);

    read2("lin", 24'h00FFFF, 2'd0, 24'h010000);
    read2("bank", 24'h00FFFF, 2'd1, 24'h000000);
    read2("page", 24'h7E12FF, 2'd2, 24'h7E1200);

    // 3-byte write, two wait cycles before each ack: 9 cycles in XFER
    start = 1'b1; start_write = 1'b1; start_len = 2'd2; start_addr = 24'h001000;
    start_wrap = 2'd0; start_wdata = 24'hABCDEF; mem_ack = 1'b0;
    tick();
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 3; c++) begin
        mem_ack = (c == 2);
        chk($sformatf("wr_req_b%0d_c%0d", b, c), req_rdwr, 1);
        chk($sformatf("wr_which_b%0d_c%0d", b, c), which_rdwr, 1);
        chk($sformatf("wr_addr_b%0d_c%0d", b, c), addr, 24'h001000 + b);
        chk($sformatf("wr_dout_b%0d_c%0d", b, c), data_out, wbytes[b]);
        chk($sformatf("wr_done_b%0d_c%0d", b, c), done, 0);
        tick();
      end
    end
    mem_ack = 1'b0;
    chk("wr_done", done, 1);
    chk("wr_req_off", req_rdwr, 0);
    chk("wr_rdata_zero", rdata, 0);
    tick();
    chk("wr_idle_busy", busy, 0);

    // start_len=3 clamps to 3 transfers; start held high while busy is ignored
    start = 1'b1; start_write = 1'b0; start_len = 2'd3; start_addr = 24'h000200;
    start_wrap = 2'd0; mem_ack = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      data_in = rbytes[b];
      chk($sformatf("clamp_addr_b%0d", b), addr, 24'h000200 + b);
      chk($sformatf("clamp_req_b%0d", b), req_rdwr, 1);
      chk($sformatf("clamp_done_b%0d", b), done, 0);
      tick();
    end
    start = 1'b0;
    chk("clamp_done", done, 1);
    chk("clamp_rdata", rdata, 24'h332211);
    chk("clamp_req_off", req_rdwr, 0);
    tick();
    chk("clamp_idle_req", req_rdwr, 0);
    tick();
    chk("clamp_no_extra_req", req_rdwr, 0);
    chk("clamp_no_extra_busy", busy, 0);

    // enable low mid-transfer with ack high: everything frozen
    start = 1'b1; start_len = 2'd1; start_addr = 24'h000300; mem_ack = 1'b1;
    tick();
    start = 1'b0; data_in = 8'h55; enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("en_addr_c%0d", c), addr, 24'h000300);
      chk($sformatf("en_req_c%0d", c), req_rdwr, 1);
      chk($sformatf("en_busy_c%0d", c), busy, 1);
      chk($sformatf("en_rdata_c%0d", c), rdata, 0);
    end
    enable = 1'b1;
    tick();
    chk("en_addr_resume", addr, 24'h000301);
    data_in = 8'h66;
    tick();
    chk("en_done", done, 1);
    chk("en_rdata", rdata, 24'h006655);
    tick();

    // reset after the first byte of a 3-byte read aborts it
    start = 1'b1; start_len = 2'd2; start_addr = 24'h000400; data_in = 8'h77;
    tick();
    start = 1'b0;
    tick();
    chk("abort_addr_pre", addr, 24'h000401);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_req", req_rdwr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_done_later", done, 0);
    tick();
    chk("abort_done_later2", done, 0);
    read2("after_rst", 24'h00FFFF, 2'd0, 24'h010000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
